// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage RISC-V pipeline: branch/jump redirect, data-memory
// req/ack access with watchdog abort, and the registered MEM/WB outputs.
module mem_access_stage #(
  parameter int unsigned WORD_SIZE      = 32,
  parameter int unsigned NUM_REGS       = 32,
  parameter int unsigned REG_SEL        = $clog2(NUM_REGS),
  parameter int unsigned ADDR_SIZE      = 10,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_SIZE-1:0] branch_target,
  input  logic [WORD_SIZE-1:0] alu_result,
  input  logic [WORD_SIZE-1:0] write_data,
  input  logic [REG_SEL-1:0]   rd,
  input  logic                 alu_zero,
  input  logic                 branch,
  input  logic                 jump,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic                 reg_write,
  output logic                 stall,
  output logic                 pc_redirect,
  output logic [ADDR_SIZE-1:0] redirect_target,
  output logic                 flush,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [ADDR_SIZE-1:0] dmem_addr,
  output logic [WORD_SIZE-1:0] dmem_wdata,
  input  logic                 dmem_ack,
  input  logic [WORD_SIZE-1:0] dmem_rdata,
  output logic [WORD_SIZE-1:0] wb_result,
  output logic [REG_SEL-1:0]   wb_rd,
  output logic                 wb_reg_write,
  output logic                 misaligned,
  output logic                 bus_error
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [WORD_SIZE-1:0] hold_alu;
  logic [REG_SEL-1:0]   hold_rd;
  logic                 hold_rw;

  logic mem_op, aligned, accept, expire;

  always_comb begin
    mem_op      = mem_read | mem_write;
    aligned     = (alu_result[1:0] == 2'b00);
    accept      = (state == IDLE) && mem_op && aligned;
    expire      = (state == BUSY) && !dmem_ack && (cnt == CNT_LAST);
    stall       = accept || ((state == BUSY) && !dmem_ack && !expire);
    pc_redirect = (state == IDLE) && (jump || (branch && alu_zero));
  end

  assign flush           = pc_redirect;
  assign redirect_target = branch_target;

  // The dmem_* registers double as the held address/data/op type while BUSY.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      hold_alu     <= '0;
      hold_rd      <= '0;
      hold_rw      <= 1'b0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      wb_result    <= '0;
      wb_rd        <= '0;
      wb_reg_write <= 1'b0;
      misaligned   <= 1'b0;
      bus_error    <= 1'b0;
    end else begin
      misaligned <= 1'b0;
      bus_error  <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_op) begin
            wb_reg_write <= 1'b0;
            if (aligned) begin
              hold_alu   <= alu_result;
              hold_rd    <= rd;
              hold_rw    <= reg_write;
              dmem_addr  <= alu_result[ADDR_SIZE+1:2];
              dmem_wdata <= write_data;
              dmem_we    <= mem_write;
              dmem_req   <= 1'b1;
              cnt        <= '0;
              state      <= BUSY;
            end else begin
              misaligned <= 1'b1;
            end
          end else begin
            wb_result    <= alu_result;
            wb_rd        <= rd;
            wb_reg_write <= reg_write;
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            dmem_req     <= 1'b0;
            wb_result    <= dmem_we ? hold_alu : dmem_rdata;
            wb_rd        <= hold_rd;
            wb_reg_write <= hold_rw;
            state        <= IDLE;
          end else if (cnt == CNT_LAST) begin
            dmem_req     <= 1'b0;
            bus_error    <= 1'b1;
            wb_reg_write <= 1'b0;
            state        <= IDLE;
          end else begin
            cnt          <= cnt + 1'b1;
            wb_reg_write <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Transaction-level bench for mem_access_stage: directed cases plus random
// instructions with random memory latency, checked against a reference model.
module tb_mem_access_stage;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  branch_target;
  logic [31:0] alu_result, write_data;
  logic [4:0]  rd;
  logic        alu_zero, branch, jump, mem_read, mem_write, reg_write;
  logic        stall, pc_redirect, flush;
  logic [9:0]  redirect_target;
  logic        dmem_req, dmem_we;
  logic [9:0]  dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] wb_result;
  logic [4:0]  wb_rd;
  logic        wb_reg_write, misaligned, bus_error;

  int n_tests = 0;
  int n_fail  = 0;

  logic        exp_rw  = 1'b0;
  logic [31:0] exp_res = '0;
  logic [4:0]  exp_rd  = '0;

  mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .branch_target(branch_target), .alu_result(alu_result),
    .write_data(write_data), .rd(rd), .alu_zero(alu_zero), .branch(branch),
    .jump(jump), .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .stall(stall), .pc_redirect(pc_redirect), .redirect_target(redirect_target),
    .flush(flush), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_result(wb_result), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .misaligned(misaligned), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // One instruction presented to the stage; w = wait cycles before ack
  // (w >= TO means the memory never answers).
  task automatic run_op(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] r,
                        input logic mr, input logic mw, input logic rw,
                        input logic br, input logic jp, input logic z,
                        input logic [9:0] tgt, input int unsigned w, input logic [31:0] rdv);
    logic mem, al, timed_out, redir;
    logic [31:0] rdat;
    alu_result = alu; write_data = wd; rd = r;
    mem_read = mr; mem_write = mw; reg_write = rw;
    branch = br; jump = jp; alu_zero = z; branch_target = tgt;
    dmem_ack = 1'($urandom_range(0, 1));
    dmem_rdata = $urandom;
    mem   = mr | mw;
    al    = (alu[1:0] == 2'b00);
    redir = jp | (br & z);
    rdat  = rdv;
    #1;
    check("stall_issue", 32'(stall), 32'(mem && al));
    check("pc_redirect", 32'(pc_redirect), 32'(redir));
    check("flush", 32'(flush), 32'(redir));
    check("redirect_target", 32'(redirect_target), 32'(tgt));
    step;
    check("misaligned", 32'(misaligned), 32'(mem && !al));
    check("bus_error_idle", 32'(bus_error), 32'd0);
    if (!mem) begin
      exp_rw = rw; exp_res = alu; exp_rd = r;
    end else if (!al) begin
      exp_rw = 1'b0;
      check("req_misaligned", 32'(dmem_req), 32'd0);
    end else begin
      timed_out = 1'b1;
      for (int unsigned j = 1; j <= TO; j++) begin
        check("req_busy", 32'(dmem_req), 32'd1);
        check("we_busy", 32'(dmem_we), 32'(mw));
        check("addr_busy", 32'(dmem_addr), 32'(alu[11:2]));
        check("wdata_busy", dmem_wdata, wd);
        check("wbwe_busy", 32'(wb_reg_write), 32'd0);
        check("redirect_busy", 32'(pc_redirect), 32'd0);
        if (j == w + 1) begin
          dmem_ack = 1'b1; dmem_rdata = rdat;
          #1;
          check("stall_ack", 32'(stall), 32'd0);
          step;
          timed_out = 1'b0;
          break;
        end
        dmem_ack = 1'b0; dmem_rdata = $urandom;
        #1;
        check("stall_wait", 32'(stall), 32'(j != TO));
        step;
      end
      check("req_done", 32'(dmem_req), 32'd0);
      check("bus_error", 32'(bus_error), 32'(timed_out));
      if (timed_out) exp_rw = 1'b0;
      else begin
        exp_rw = rw; exp_rd = r;
        exp_res = mw ? alu : rdat;
      end
    end
    check("wb_reg_write", 32'(wb_reg_write), 32'(exp_rw));
    if (exp_rw) begin
      check("wb_result", wb_result, exp_res);
      check("wb_rd", 32'(wb_rd), 32'(exp_rd));
    end
    dmem_ack = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"}, 32'(dmem_req), 32'd0);
    check({tag, "_we"}, 32'(dmem_we), 32'd0);
    check({tag, "_addr"}, 32'(dmem_addr), 32'd0);
    check({tag, "_wdata"}, dmem_wdata, 32'd0);
    check({tag, "_wbres"}, wb_result, 32'd0);
    check({tag, "_wbrd"}, 32'(wb_rd), 32'd0);
    check({tag, "_wbwe"}, 32'(wb_reg_write), 32'd0);
    check({tag, "_mis"}, 32'(misaligned), 32'd0);
    check({tag, "_berr"}, 32'(bus_error), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic mr, mw;
    int unsigned kind;
    logic [31:0] a;
    rst = 1'b0;
    branch_target = '0; alu_result = 32'h10; write_data = '0; rd = 5'd5;
    alu_zero = 0; branch = 0; jump = 0; mem_read = 1; mem_write = 0; reg_write = 1;
    dmem_ack = 0; dmem_rdata = '0;
    step; check("reset1_req", 32'(dmem_req), 32'd0);
    step; check_all_zero("reset");
    mem_read = 0; reg_write = 0;
    rst = 1'b1;

    run_op(32'h10, 32'h0, 5'd5, 1, 0, 1, 0, 0, 0, 10'h0, 0, 32'hDEAD_BEEF);
    run_op(32'h20, 32'h1234_5678, 5'd7, 0, 1, 0, 0, 0, 0, 10'h0, 3, 32'h0);
    run_op(32'h5, 32'h0, 5'd1, 0, 0, 0, 1, 0, 1, 10'h3C, 0, 32'h0);
    run_op(32'h5, 32'h0, 5'd1, 0, 0, 0, 1, 0, 0, 10'h3C, 0, 32'h0);
    run_op(32'h5, 32'h0, 5'd1, 0, 0, 1, 0, 1, 0, 10'h3C, 0, 32'h0);
    run_op(32'h13, 32'h0, 5'd3, 1, 0, 1, 0, 0, 0, 10'h0, 0, 32'h0);
    run_op(32'h44, 32'h0, 5'd9, 1, 0, 1, 0, 0, 0, 10'h0, TO, 32'h0);
    run_op(32'h48, 32'hCAFE_F00D, 5'd11, 1, 1, 1, 0, 0, 0, 10'h0, 1, 32'h0);

    // Reset while an access is outstanding.
    alu_result = 32'h40; mem_read = 1; mem_write = 0; reg_write = 1; rd = 5'd2;
    branch = 0; jump = 0; dmem_ack = 0;
    step;
    step;
    check("rstbusy_req_before", 32'(dmem_req), 32'd1);
    rst = 1'b0;
    step;
    check_all_zero("rstbusy");
    rst = 1'b1; mem_read = 0; reg_write = 0;
    #1;
    check("rstbusy_idle_stall", 32'(stall), 32'd0);
    step;
    exp_rw = 1'b0;

    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 3);
      a = $urandom;
      if (kind == 0) begin
        mr = 0; mw = 0;
      end else begin
        mr = 1'($urandom_range(0, 1));
        mw = !mr | 1'($urandom_range(0, 1));
        if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
      end
      run_op(a, $urandom, 5'($urandom), mr, mw, 1'($urandom_range(0, 1)),
             (kind == 0) & 1'($urandom_range(0, 1)), (kind == 0) & 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 10'($urandom), $urandom_range(0, TO), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
